pcs_receive: RTL and testbench
==============================

Name: pcs_receive

Overview:
- 1000BASE-X PCS receive path: the far-end counterpart of the transmit/code-group encoder.
- Consumes one 10-bit code-group per GTX_CLK from the synchronisation/deserialiser stage.
- Decodes 8b/10b, tracks ordered sets (/K28.5/, /S/, /T/, /R/, /V/) and drives the GMII receive side (RXD, RX_DV, RX_ER) plus the `receiving` flag that the transmit side uses for carrier/collision.

Parameters:
ERR_CNT_W, 8, width of saturating invalid-code-group counter

Ports:
GTX_CLK  input  1  receive clock, one code-group per rising edge
RESET  input  1  asynchronous, active-low reset
rx_code_group  input  10  code-group; bit9..4 = abcdei, bit3..0 = fghj
sync_status  input  1  1 = upstream code-group alignment acquired
RXD  output  8  GMII receive data
RX_DV  output  1  GMII receive data valid
RX_ER  output  1  GMII receive error
receiving  output  1  1 while a frame or false carrier is in progress
err_count  output  ERR_CNT_W  saturating count of invalid code-groups

Behaviour:
- Reset (RESET=0, async):
  - state=WAIT_FOR_K.
  - RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0, err_count=0.
- Latency: code-group sampled at edge N drives outputs registered at edge N (valid after N, before N+1). No internal skid.
- Decode:
  - 6b->5b and 4b->3b tables, accepting both disparity forms. Octet = HGF:EDCBA.
  - K recognised: K28.5, K27.7=/S/, K29.7=/T/, K23.7=/R/, K30.7=/V/. All other K-groups and non-table patterns are INVALID.
  - Every INVALID increments err_count, saturating at all-ones. The counter is not cleared except by reset.
- sync_status=0: forces WAIT_FOR_K next edge, regardless of state. RX_DV=0, RX_ER=0, receiving=0. Overrides every transition below.
- States (default outputs RX_DV=0, RX_ER=0, RXD holds last value, receiving=0):
  - WAIT_FOR_K: K28.5 with sync_status=1 -> RX_K; else stay.
  - RX_K: data code-group -> IDLE_D; anything else -> WAIT_FOR_K.
  - IDLE_D:
    - K28.5 -> RX_K.
    - /S/ -> RECEIVE: RXD=8'h55, RX_DV=1, receiving=1.
    - Anything else (D, other K, INVALID) -> FALSE_CARRIER: RXD=8'h0E, RX_ER=1, RX_DV=0, receiving=1.
  - FALSE_CARRIER: stays (RXD=8'h0E, RX_ER=1, receiving=1) until K28.5 -> RX_K (outputs default that cycle).
  - RECEIVE (receiving=1):
    - D -> RXD=octet, RX_DV=1.
    - /T/ -> END: RX_DV=0, receiving=0.
    - K28.5 (early end) -> RX_K: RX_DV=1, RX_ER=1 for that one cycle, receiving=0.
    - /V/, other K, INVALID -> stay: RX_DV=1, RX_ER=1, RXD=8'h00.
  - END:
    - /R/ -> stay.
    - K28.5 -> RX_K.
    - Else -> WAIT_FOR_K, RX_ER=0.
- Simultaneous: INVALID in any state still counts, even when sync_status=0.
- Back-to-back frames: /T/ /R/ /K28.5/ D /S/ ... re-enters RECEIVE. No minimum IPG is checked.

Optional Feature:
- Macro RD_CHECK_EN.
- Defined:
  - Running disparity is tracked: reset RD-, updated per 6b and 4b sub-block per IEEE rules.
  - A code-group whose sub-block is illegal for the current RD is INVALID (counted; handled as INVALID above).
  - After an invalid code-group, RD = the disparity the received code-group implies.
- Not defined: no RD state; both columns are always accepted.

Test Plan:
- Idle lock: sync_status=1, repeat {0x0FA K28.5, 0x1B5 D16.2} -> states cycle RX_K/IDLE_D; RX_DV=0, RX_ER=0, receiving=0, err_count=0.
- Frame: idle, 0x368 /S/, 0x296 D5.6, 0x274 D0.0, 0x2E8 /T/, 0x3A8 /R/, 0x0FA -> RXD 55,C5,00 with RX_DV=1 for 3 cycles, RX_DV=0 on /T/, receiving 1 for exactly 3 cycles.
- False carrier: in IDLE_D send 0x296 twice, then 0x0FA -> RXD=0E, RX_ER=1, receiving=1 for 2 cycles, then all 0.
- Error in frame: /S/, 0x000, 0x296, /T/ -> second cycle RX_DV=1, RX_ER=1, RXD=00; third RXD=C5, RX_ER=0; err_count=1.
- Mid-frame sync loss and reset: sync_status=0 during RECEIVE -> next edge RX_DV=0, receiving=0, WAIT_FOR_K. RESET=0 asynchronously mid-frame -> outputs immediately 0, err_count=0.
- Saturation and RD: ERR_CNT_W=2, 5 INVALIDs -> err_count=3. With RD_CHECK_EN, 0x305 (K28.5 RD+) at RD- -> err_count increments; without the macro, no increment.

Source files
------------

// File: rtl/pcs_receive.sv
// pcs_receive: 1000BASE-X PCS receive path.
// Decodes one 10-bit code-group per GTX_CLK, tracks ordered sets and drives the GMII
// receive side plus the receiving flag. Optional macro RD_CHECK_EN adds running-disparity
// checking; without it both disparity columns are always accepted.
//
// state         | meaning
// WAIT_FOR_K    | hunting for a comma (K28.5)
// RX_K          | comma seen, expecting the data half of an ordered set
// IDLE_D        | inter-frame idle, /S/ starts a frame
// RECEIVE       | inside a frame, data octets go to RXD
// FALSE_CARRIER | activity that was not a valid start of frame
// END           | /T/ seen, absorbing /R/ until the next comma
module pcs_receive #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 GTX_CLK,
  input  logic                 RESET,
  input  logic [9:0]           rx_code_group,
  input  logic                 sync_status,
  output logic [7:0]           RXD,
  output logic                 RX_DV,
  output logic                 RX_ER,
  output logic                 receiving,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, FALSE_CARRIER, END
  } state_t;

  state_t      state;
  logic [5:0]  six;
  logic [3:0]  four;
  logic        val6, val4, is_data, is_k285, is_s, is_t, is_r, is_v, table_ok, code_invalid;
  logic [4:0]  edcba;
  logic [2:0]  hgf;
  logic [1:0]  grp;   // 1: D17/18/20, 2: D11/13/14 (the only users of the alternate x.7)
  logic        d_ok, k285_ok, s_ok, t_ok, r_ok;

  assign six  = rx_code_group[9:4];
  assign four = rx_code_group[3:0];

  // 5b/6b and 3b/4b lookup, both disparity columns, plus the five recognised K-groups
  always_comb begin
    val6  = 1'b1;
    edcba = 5'd0;
    grp   = 2'd0;
    case (six)
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100: begin edcba = 5'd11; grp = 2'd2; end
      6'b001101:            edcba = 5'd12;
      6'b101100: begin edcba = 5'd13; grp = 2'd2; end
      6'b011100: begin edcba = 5'd14; grp = 2'd2; end
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011: begin edcba = 5'd17; grp = 2'd1; end
      6'b010011: begin edcba = 5'd18; grp = 2'd1; end
      6'b110010:            edcba = 5'd19;
      6'b001011: begin edcba = 5'd20; grp = 2'd1; end
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110:            edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      default:              val6  = 1'b0;
    endcase

    val4 = 1'b1;
    hgf  = 3'd0;
    case (four)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      // x.7 primary form is barred where it would make a run of five
      4'b1110: begin hgf = 3'd7; val4 = (grp != 2'd1); end
      4'b0001: begin hgf = 3'd7; val4 = (grp != 2'd2); end
      4'b0111: begin hgf = 3'd7; val4 = (grp == 2'd1); end
      4'b1000: begin hgf = 3'd7; val4 = (grp == 2'd2); end
      default: val4 = 1'b0;
    endcase

    is_data = val6 & val4;
    is_k285 = (rx_code_group == 10'b001111_1010) || (rx_code_group == 10'b110000_0101);
    is_s    = (rx_code_group == 10'b110110_1000) || (rx_code_group == 10'b001001_0111);
    is_t    = (rx_code_group == 10'b101110_1000) || (rx_code_group == 10'b010001_0111);
    is_r    = (rx_code_group == 10'b111010_1000) || (rx_code_group == 10'b000101_0111);
    is_v    = (rx_code_group == 10'b011110_1000) || (rx_code_group == 10'b100001_0111);
    table_ok = is_data | is_k285 | is_s | is_t | is_r | is_v;
  end

`ifdef RD_CHECK_EN
  logic       rd, rd_mid, rd_next, ok6, ok4;
  logic [2:0] ones6, ones4;

  // Sub-block disparity legality and running-disparity update; an illegal group still
  // leaves RD where its own sub-blocks imply
  always_comb begin
    ones6   = 3'($countones(six));
    ones4   = 3'($countones(four));
    ok6     = rd ? (ones6 <= 3'd3 && six != 6'b111000) : (ones6 >= 3'd3 && six != 6'b000111);
    rd_mid  = (ones6 > 3'd3 || six == 6'b000111) ? 1'b1 :
              (ones6 < 3'd3 || six == 6'b111000) ? 1'b0 : rd;
    ok4     = rd_mid ? (ones4 <= 3'd2 && four != 4'b1100) : (ones4 >= 3'd2 && four != 4'b0011);
    rd_next = (ones4 > 3'd2 || four == 4'b0011) ? 1'b1 :
              (ones4 < 3'd2 || four == 4'b1100) ? 1'b0 : rd_mid;
    code_invalid = ~table_ok | ~(ok6 & ok4);
  end

  // Running disparity register, starts negative
  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) rd <= 1'b0;
    else        rd <= rd_next;
  end
`else
  assign code_invalid = ~table_ok;
`endif

  assign d_ok    = is_data & ~code_invalid;
  assign k285_ok = is_k285 & ~code_invalid;
  assign s_ok    = is_s    & ~code_invalid;
  assign t_ok    = is_t    & ~code_invalid;
  assign r_ok    = is_r    & ~code_invalid;

  // Saturating invalid code-group counter, counts regardless of sync or state
  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET)                                  err_count <= '0;
    else if (code_invalid && err_count != '1)    err_count <= err_count + 1'b1;
  end

  // Receive state machine with registered GMII outputs; RXD holds unless written
  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= WAIT_FOR_K;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
    end else begin
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
      if (!sync_status) begin
        state <= WAIT_FOR_K;
      end else begin
        case (state)
          WAIT_FOR_K: if (k285_ok) state <= RX_K;
          RX_K:       state <= d_ok ? IDLE_D : WAIT_FOR_K;
          IDLE_D: begin
            if (k285_ok) begin
              state <= RX_K;
            end else if (s_ok) begin
              state     <= RECEIVE;
              RXD       <= 8'h55;
              RX_DV     <= 1'b1;
              receiving <= 1'b1;
            end else begin
              state     <= FALSE_CARRIER;
              RXD       <= 8'h0E;
              RX_ER     <= 1'b1;
              receiving <= 1'b1;
            end
          end
          FALSE_CARRIER: begin
            if (k285_ok) begin
              state <= RX_K;
            end else begin
              RXD       <= 8'h0E;
              RX_ER     <= 1'b1;
              receiving <= 1'b1;
            end
          end
          RECEIVE: begin
            if (d_ok) begin
              RXD       <= {hgf, edcba};
              RX_DV     <= 1'b1;
              receiving <= 1'b1;
            end else if (t_ok) begin
              state <= END;
            end else if (k285_ok) begin
              // comma inside a frame: flag the truncated frame for one cycle
              state <= RX_K;
              RX_DV <= 1'b1;
              RX_ER <= 1'b1;
            end else begin
              RXD       <= 8'h00;
              RX_DV     <= 1'b1;
              RX_ER     <= 1'b1;
              receiving <= 1'b1;
            end
          end
          END: begin
            if (r_ok)         state <= END;
            else if (k285_ok) state <= RX_K;
            else              state <= WAIT_FOR_K;
          end
          default: state <= WAIT_FOR_K;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcs_receive.sv
// tb_pcs_receive: directed vector bench for pcs_receive (default build; the running
// disparity expectation follows RD_CHECK_EN when it is defined).
module tb_pcs_receive;

  logic        GTX_CLK = 1'b0;
  logic        RESET;
  logic [9:0]  rx_code_group;
  logic        sync_status;
  logic [7:0]  RXD;
  logic        RX_DV, RX_ER, receiving;
  logic [7:0]  err_count;
  logic [7:0]  s_rxd;
  logic        s_dv, s_er, s_recv;
  logic [1:0]  s_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] cg;
    logic       sync;
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    logic       recv;
    logic [7:0] errc;
  } vec_t;

  vec_t vecs[$];

  pcs_receive #(.ERR_CNT_W(8)) dut (
    .GTX_CLK(GTX_CLK), .RESET(RESET), .rx_code_group(rx_code_group),
    .sync_status(sync_status), .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
    .receiving(receiving), .err_count(err_count)
  );

  pcs_receive #(.ERR_CNT_W(2)) dut_small (
    .GTX_CLK(GTX_CLK), .RESET(RESET), .rx_code_group(rx_code_group),
    .sync_status(sync_status), .RXD(s_rxd), .RX_DV(s_dv), .RX_ER(s_er),
    .receiving(s_recv), .err_count(s_err)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  function automatic void add(input logic [9:0] cg, input logic sync, input logic [7:0] rxd,
                              input logic dv, input logic er, input logic recv,
                              input logic [7:0] errc);
    vec_t v;
    v.cg = cg; v.sync = sync; v.rxd = rxd; v.dv = dv; v.er = er; v.recv = recv; v.errc = errc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] cg, input logic sync);
    rx_code_group = cg;
    sync_status   = sync;
    @(posedge GTX_CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // idle lock
    add(10'h0FA, 1, 8'h00, 0, 0, 0, 0);
    add(10'h1B5, 1, 8'h00, 0, 0, 0, 0);
    add(10'h0FA, 1, 8'h00, 0, 0, 0, 0);
    add(10'h1B5, 1, 8'h00, 0, 0, 0, 0);
    // frame /S/ D5.6 D0.0 /T/ /R/
    add(10'h368, 1, 8'h55, 1, 0, 1, 0);
    add(10'h296, 1, 8'hC5, 1, 0, 1, 0);
    add(10'h274, 1, 8'h00, 1, 0, 1, 0);
    add(10'h2E8, 1, 8'h00, 0, 0, 0, 0);
    add(10'h3A8, 1, 8'h00, 0, 0, 0, 0);
    add(10'h0FA, 1, 8'h00, 0, 0, 0, 0);
    add(10'h1B5, 1, 8'h00, 0, 0, 0, 0);
    // false carrier
    add(10'h296, 1, 8'h0E, 0, 1, 1, 0);
    add(10'h296, 1, 8'h0E, 0, 1, 1, 0);
    add(10'h0FA, 1, 8'h0E, 0, 0, 0, 0);
    add(10'h1B5, 1, 8'h0E, 0, 0, 0, 0);
    // invalid inside a frame
    add(10'h368, 1, 8'h55, 1, 0, 1, 0);
    add(10'h000, 1, 8'h00, 1, 1, 1, 1);
    add(10'h296, 1, 8'hC5, 1, 0, 1, 1);
    add(10'h2E8, 1, 8'hC5, 0, 0, 0, 1);
    // back-to-back frame, bad x.7 form, D17.7, D11.7, early end on comma
    add(10'h3A8, 1, 8'hC5, 0, 0, 0, 1);
    add(10'h0FA, 1, 8'hC5, 0, 0, 0, 1);
    add(10'h1B5, 1, 8'hC5, 0, 0, 0, 1);
    add(10'h368, 1, 8'h55, 1, 0, 1, 1);
    add(10'h298, 1, 8'h00, 1, 1, 1, 2);
    add(10'h237, 1, 8'hF1, 1, 0, 1, 2);
    add(10'h348, 1, 8'hEB, 1, 0, 1, 2);
    add(10'h0FA, 1, 8'hEB, 1, 1, 0, 2);
    add(10'h1B5, 1, 8'hEB, 0, 0, 0, 2);
    // /V/ in a frame
    add(10'h368, 1, 8'h55, 1, 0, 1, 2);
    add(10'h1E8, 1, 8'h00, 1, 1, 1, 2);
    add(10'h296, 1, 8'hC5, 1, 0, 1, 2);
    // sync loss mid-frame, then RX_K followed by a non-data group
    add(10'h296, 0, 8'hC5, 0, 0, 0, 2);
    add(10'h1B5, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h0FA, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h0FA, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h1B5, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h368, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h0FA, 1, 8'hC5, 0, 0, 0, 2);
    add(10'h1B5, 1, 8'hC5, 0, 0, 0, 2);
    // invalid while out of sync still counts; other K-group in idle is false carrier
    add(10'h000, 0, 8'hC5, 0, 0, 0, 3);
    add(10'h0FA, 1, 8'hC5, 0, 0, 0, 3);
    add(10'h1B5, 1, 8'hC5, 0, 0, 0, 3);
    add(10'h0F4, 1, 8'h0E, 0, 1, 1, 4);
    add(10'h368, 1, 8'h0E, 0, 1, 1, 4);
    add(10'h0FA, 1, 8'h0E, 0, 0, 0, 4);
    add(10'h3FF, 1, 8'h0E, 0, 0, 0, 5);
    add(10'h305, 1, 8'h0E, 0, 0, 0, 5);
    add(10'h1B5, 1, 8'h0E, 0, 0, 0, 5);
    add(10'h1E8, 1, 8'h0E, 0, 1, 1, 5);
    add(10'h0FA, 1, 8'h0E, 0, 0, 0, 5);

    RESET = 1'b0;
    rx_code_group = 10'h000;
    sync_status = 1'b0;
    #12;
    check("reset rxd", RXD, 8'h00);
    check("reset dv", {7'b0, RX_DV}, 8'h00);
    check("reset er", {7'b0, RX_ER}, 8'h00);
    check("reset recv", {7'b0, receiving}, 8'h00);
    check("reset err", err_count, 8'h00);
    @(negedge GTX_CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cg, vecs[i].sync);
      check($sformatf("vec%0d rxd", i), RXD, vecs[i].rxd);
      check($sformatf("vec%0d dv", i), {7'b0, RX_DV}, {7'b0, vecs[i].dv});
      check($sformatf("vec%0d er", i), {7'b0, RX_ER}, {7'b0, vecs[i].er});
      check($sformatf("vec%0d recv", i), {7'b0, receiving}, {7'b0, vecs[i].recv});
      check($sformatf("vec%0d err", i), err_count, vecs[i].errc);
    end

    // asynchronous reset in the middle of a frame
    step(10'h1B5, 1);
    step(10'h368, 1);
    check("pre-reset dv", {7'b0, RX_DV}, 8'h01);
    #3;
    RESET = 1'b0;
    #1;
    check("async rst rxd", RXD, 8'h00);
    check("async rst dv", {7'b0, RX_DV}, 8'h00);
    check("async rst recv", {7'b0, receiving}, 8'h00);
    check("async rst err", err_count, 8'h00);
    @(negedge GTX_CLK);
    RESET = 1'b1;

    // counter saturation on the 2-bit instance
    for (int i = 1; i <= 5; i++) begin
      step(10'h000, 1);
      check($sformatf("sat%0d wide err", i), err_count, 8'(i));
      check($sformatf("sat%0d narrow err", i), {6'b0, s_err}, (i > 3) ? 8'd3 : 8'(i));
    end

    // K28.5 in its RD+ form at the reset disparity (RD-)
    @(negedge GTX_CLK);
    RESET = 1'b0;
    @(negedge GTX_CLK);
    RESET = 1'b1;
    step(10'h305, 1);
`ifdef RD_CHECK_EN
    check("rd k28.5+ at rd-", err_count, 8'd1);
`else
    check("rd k28.5+ at rd-", err_count, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
